// File: rtl/reg_file_param.sv
// Parametrised multi-port CPU register file: one write port, two read ports and a
// mirror of register OUT_ADDR on cpu_out. Supports a hard-wired zero register,
// write-to-read bypass and an optional registered read path.
module reg_file_param #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter bit          ZERO_REG   = 1'b1,
    parameter bit          BYPASS     = 1'b1,
    parameter bit          SYNC_READ  = 1'b0,
    parameter int unsigned OUT_ADDR   = 2**ADDR_WIDTH - 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] RA1,
    input  logic [ADDR_WIDTH-1:0] RA2,
    input  logic [ADDR_WIDTH-1:0] WA,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic                  write_enable,
    input  logic                  clear,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    output logic [DATA_WIDTH-1:0] cpu_out
);

    localparam int unsigned DEPTH = 2**ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] OUT_IDX = OUT_ADDR[ADDR_WIDTH-1:0];

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DATA_WIDTH-1:0] rd1_c;
    logic [DATA_WIDTH-1:0] rd2_c;
    logic                  wr_ok;

    assign wr_ok = write_enable && !(ZERO_REG && (WA == '0));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (wr_ok) begin
            regs[WA] <= ALUResult;
        end
    end

    // Zero register wins over bypass; clear suppresses bypass since the write is lost.
    function automatic logic [DATA_WIDTH-1:0] read_port(
        input logic [ADDR_WIDTH-1:0] ra,
        input logic [ADDR_WIDTH-1:0] wa,
        input logic                  we,
        input logic                  clr,
        input logic [DATA_WIDTH-1:0] wd,
        input logic [DATA_WIDTH-1:0] stored
    );
        if (ZERO_REG && (ra == '0))
            return '0;
        else if (BYPASS && we && !clr && (ra == wa))
            return wd;
        else
            return stored;
    endfunction

    always_comb begin
        rd1_c = read_port(RA1, WA, write_enable, clear, ALUResult, regs[RA1]);
        rd2_c = read_port(RA2, WA, write_enable, clear, ALUResult, regs[RA2]);
    end

    generate
        if (SYNC_READ) begin : g_sync_read
            logic [DATA_WIDTH-1:0] rd1_q;
            logic [DATA_WIDTH-1:0] rd2_q;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    rd1_q <= '0;
                    rd2_q <= '0;
                end else if (clear) begin
                    rd1_q <= '0;
                    rd2_q <= '0;
                end else begin
                    rd1_q <= rd1_c;
                    rd2_q <= rd2_c;
                end
            end

            assign RD1 = rd1_q;
            assign RD2 = rd2_q;
        end else begin : g_comb_read
            assign RD1 = rd1_c;
            assign RD2 = rd2_c;
        end
    endgenerate

    assign cpu_out = regs[OUT_IDX];

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default configuration, a no-bypass/no-zero-reg
// variant sharing its inputs, and a wide registered-read variant.
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  ra1, ra2, wa;
    logic [7:0]  wd;
    logic        we, clr;
    logic [7:0]  d_rd1, d_rd2, d_cpu;
    logic [7:0]  n_rd1, n_rd2, n_cpu;

    logic [4:0]  s_ra1, s_ra2, s_wa;
    logic [15:0] s_wd;
    logic        s_we, s_clr;
    logic [15:0] s_rd1, s_rd2, s_cpu;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_param u_dut (
        .clk(clk), .reset(rst_n), .RA1(ra1), .RA2(ra2), .WA(wa), .ALUResult(wd),
        .write_enable(we), .clear(clr), .RD1(d_rd1), .RD2(d_rd2), .cpu_out(d_cpu)
    );

    reg_file_param #(.ZERO_REG(1'b0), .BYPASS(1'b0)) u_nb (
        .clk(clk), .reset(rst_n), .RA1(ra1), .RA2(ra2), .WA(wa), .ALUResult(wd),
        .write_enable(we), .clear(clr), .RD1(n_rd1), .RD2(n_rd2), .cpu_out(n_cpu)
    );

    reg_file_param #(.DATA_WIDTH(16), .ADDR_WIDTH(5), .SYNC_READ(1'b1)) u_sync (
        .clk(clk), .reset(rst_n), .RA1(s_ra1), .RA2(s_ra2), .WA(s_wa), .ALUResult(s_wd),
        .write_enable(s_we), .clear(s_clr), .RD1(s_rd1), .RD2(s_rd2), .cpu_out(s_cpu)
    );

    task automatic test_reset;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (d_rd1 !== 8'h00) begin errors++; $display("FAIL reset_d_rd1 got %h exp 00", d_rd1); end
        checks++; if (d_rd2 !== 8'h00) begin errors++; $display("FAIL reset_d_rd2 got %h exp 00", d_rd2); end
        checks++; if (d_cpu !== 8'h00) begin errors++; $display("FAIL reset_d_cpu got %h exp 00", d_cpu); end
        checks++; if (n_rd1 !== 8'h00) begin errors++; $display("FAIL reset_n_rd1 got %h exp 00", n_rd1); end
        checks++; if (s_rd1 !== 16'h0000) begin errors++; $display("FAIL reset_s_rd1 got %h exp 0000", s_rd1); end
        checks++; if (s_rd2 !== 16'h0000) begin errors++; $display("FAIL reset_s_rd2 got %h exp 0000", s_rd2); end
        checks++; if (s_cpu !== 16'h0000) begin errors++; $display("FAIL reset_s_cpu got %h exp 0000", s_cpu); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_write_read;
        @(negedge clk);
        we = 1'b1; wa = 4'd10; wd = 8'h03;
        @(posedge clk); #1;
        @(negedge clk);
        we = 1'b0; ra1 = 4'd10; ra2 = 4'd2;
        #1;
        checks++; if (d_rd1 !== 8'h03) begin errors++; $display("FAIL wr_d_rd1 got %h exp 03", d_rd1); end
        checks++; if (d_rd2 !== 8'h00) begin errors++; $display("FAIL wr_d_rd2 got %h exp 00", d_rd2); end
        checks++; if (d_cpu !== 8'h00) begin errors++; $display("FAIL wr_d_cpu got %h exp 00", d_cpu); end
        checks++; if (n_rd1 !== 8'h03) begin errors++; $display("FAIL wr_n_rd1 got %h exp 03", n_rd1); end
    endtask

    task automatic test_bypass;
        @(negedge clk);
        we = 1'b1; wa = 4'd5; wd = 8'h24; ra1 = 4'd5; ra2 = 4'd5;
        #1;
        checks++; if (d_rd1 !== 8'h24) begin errors++; $display("FAIL byp_d_rd1 got %h exp 24", d_rd1); end
        checks++; if (d_rd2 !== 8'h24) begin errors++; $display("FAIL byp_d_rd2 got %h exp 24", d_rd2); end
        checks++; if (n_rd1 !== 8'h00) begin errors++; $display("FAIL nobyp_pre got %h exp 00", n_rd1); end
        @(posedge clk); #1;
        checks++; if (n_rd1 !== 8'h24) begin errors++; $display("FAIL nobyp_post got %h exp 24", n_rd1); end
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++; if (d_rd1 !== 8'h24) begin errors++; $display("FAIL byp_stored got %h exp 24", d_rd1); end
    endtask

    task automatic test_zero_reg;
        @(negedge clk);
        we = 1'b1; wa = 4'd0; wd = 8'hFF; ra1 = 4'd0; ra2 = 4'd0;
        #1;
        checks++; if (d_rd1 !== 8'h00) begin errors++; $display("FAIL zero_byp got %h exp 00", d_rd1); end
        checks++; if (n_rd1 !== 8'h00) begin errors++; $display("FAIL nozero_pre got %h exp 00", n_rd1); end
        @(posedge clk); #1;
        checks++; if (d_rd1 !== 8'h00) begin errors++; $display("FAIL zero_post got %h exp 00", d_rd1); end
        checks++; if (n_rd1 !== 8'hFF) begin errors++; $display("FAIL nozero_post got %h exp FF", n_rd1); end
        @(negedge clk);
        we = 1'b0;
        #1;
        checks++; if (d_rd2 !== 8'h00) begin errors++; $display("FAIL zero_later got %h exp 00", d_rd2); end
        checks++; if (n_rd2 !== 8'hFF) begin errors++; $display("FAIL nozero_later got %h exp FF", n_rd2); end
    endtask

    task automatic test_clear;
        @(negedge clk);
        we = 1'b1; wa = 4'd15; wd = 8'hF1; ra1 = 4'd15;
        #1;
        checks++; if (d_cpu !== 8'h00) begin errors++; $display("FAIL cpu_not_bypassed got %h exp 00", d_cpu); end
        checks++; if (d_rd1 !== 8'hF1) begin errors++; $display("FAIL cpu_byp_rd1 got %h exp F1", d_rd1); end
        @(posedge clk); #1;
        checks++; if (d_cpu !== 8'hF1) begin errors++; $display("FAIL cpu_out got %h exp F1", d_cpu); end
        @(negedge clk);
        clr = 1'b1; we = 1'b1; wa = 4'd15; wd = 8'h77; ra1 = 4'd15; ra2 = 4'd5;
        #1;
        checks++; if (d_rd1 !== 8'hF1) begin errors++; $display("FAIL clr_no_byp got %h exp F1", d_rd1); end
        checks++; if (d_rd2 !== 8'h24) begin errors++; $display("FAIL clr_pre_rd2 got %h exp 24", d_rd2); end
        @(posedge clk); #1;
        checks++; if (d_cpu !== 8'h00) begin errors++; $display("FAIL clr_cpu got %h exp 00", d_cpu); end
        checks++; if (d_rd1 !== 8'h00) begin errors++; $display("FAIL clr_rd1 got %h exp 00", d_rd1); end
        checks++; if (d_rd2 !== 8'h00) begin errors++; $display("FAIL clr_rd2 got %h exp 00", d_rd2); end
        checks++; if (n_cpu !== 8'h00) begin errors++; $display("FAIL clr_n_cpu got %h exp 00", n_cpu); end
        @(negedge clk);
        clr = 1'b0; we = 1'b0;
    endtask

    task automatic test_sync_read;
        @(negedge clk);
        s_we = 1'b1; s_wa = 5'd20; s_wd = 16'hBEEF;
        @(posedge clk); #1;
        @(negedge clk);
        s_we = 1'b0; s_ra2 = 5'd20;
        #1;
        checks++; if (s_rd2 !== 16'h0000) begin errors++; $display("FAIL sync_early got %h exp 0000", s_rd2); end
        @(posedge clk); #1;
        checks++; if (s_rd2 !== 16'hBEEF) begin errors++; $display("FAIL sync_rd2 got %h exp BEEF", s_rd2); end
        @(negedge clk);
        s_we = 1'b1; s_wa = 5'd7; s_wd = 16'h1234; s_ra1 = 5'd7;
        #1;
        checks++; if (s_rd1 !== 16'h0000) begin errors++; $display("FAIL sync_byp_pre got %h exp 0000", s_rd1); end
        @(posedge clk); #1;
        checks++; if (s_rd1 !== 16'h1234) begin errors++; $display("FAIL sync_byp got %h exp 1234", s_rd1); end
        @(negedge clk);
        s_we = 1'b0; s_clr = 1'b1; s_ra1 = 5'd20;
        @(posedge clk); #1;
        checks++; if (s_rd1 !== 16'h0000) begin errors++; $display("FAIL sync_clr_rd1 got %h exp 0000", s_rd1); end
        checks++; if (s_rd2 !== 16'h0000) begin errors++; $display("FAIL sync_clr_rd2 got %h exp 0000", s_rd2); end
        @(negedge clk);
        s_clr = 1'b0;
        @(posedge clk); #1;
        checks++; if (s_rd2 !== 16'h0000) begin errors++; $display("FAIL sync_cleared got %h exp 0000", s_rd2); end
    endtask

    task automatic test_async_reset;
        logic [3:0] addrs [4];
        logic [7:0] vals  [4];
        addrs = '{4'd1, 4'd2, 4'd3, 4'd15};
        vals  = '{8'h11, 8'h22, 8'h33, 8'h44};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            we = 1'b1; wa = addrs[i]; wd = vals[i];
            s_we = 1'b1; s_wa = 5'd4; s_wd = 16'hABCD; s_ra1 = 5'd4;
            @(posedge clk); #1;
        end
        @(negedge clk);
        we = 1'b0; s_we = 1'b0; ra1 = 4'd1; ra2 = 4'd3;
        #1;
        checks++; if (d_rd1 !== 8'h11) begin errors++; $display("FAIL load_rd1 got %h exp 11", d_rd1); end
        checks++; if (d_rd2 !== 8'h33) begin errors++; $display("FAIL load_rd2 got %h exp 33", d_rd2); end
        checks++; if (d_cpu !== 8'h44) begin errors++; $display("FAIL load_cpu got %h exp 44", d_cpu); end
        checks++; if (s_rd1 !== 16'hABCD) begin errors++; $display("FAIL load_s_rd1 got %h exp ABCD", s_rd1); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (d_rd1 !== 8'h00) begin errors++; $display("FAIL arst_rd1 got %h exp 00", d_rd1); end
        checks++; if (d_rd2 !== 8'h00) begin errors++; $display("FAIL arst_rd2 got %h exp 00", d_rd2); end
        checks++; if (d_cpu !== 8'h00) begin errors++; $display("FAIL arst_cpu got %h exp 00", d_cpu); end
        checks++; if (s_rd1 !== 16'h0000) begin errors++; $display("FAIL arst_s_rd1 got %h exp 0000", s_rd1); end
        @(negedge clk);
        we = 1'b1; wa = 4'd2; wd = 8'h55;
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1; we = 1'b0; ra1 = 4'd2; ra2 = 4'd15;
        #1;
        checks++; if (d_rd1 !== 8'h00) begin errors++; $display("FAIL rst_write_lost got %h exp 00", d_rd1); end
        checks++; if (d_rd2 !== 8'h00) begin errors++; $display("FAIL post_rst_r15 got %h exp 00", d_rd2); end
        ra1 = 4'd3;
        #1;
        checks++; if (d_rd1 !== 8'h00) begin errors++; $display("FAIL post_rst_r3 got %h exp 00", d_rd1); end
    endtask

    initial begin
        ra1 = '0; ra2 = '0; wa = '0; wd = '0; we = 1'b0; clr = 1'b0;
        s_ra1 = '0; s_ra2 = '0; s_wa = '0; s_wd = '0; s_we = 1'b0; s_clr = 1'b0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_sync_read();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised successor to the 8-bit, 16-entry, 2-read/1-write CPU register file. It is generalised in data width and depth. It adds an asynchronous active-low reset, an optional hard-wired zero register and optional write-to-read bypass. It also adds a selectable registered-read mode, a synchronous bulk clear, and a dedicated output register mirrored to cpu_out. It sits between the decode stage (read/write addresses) and the ALU (operands in, ALUResult back).

Parameters:
DATA_WIDTH, 8, bits per register.
ADDR_WIDTH, 4, address bits; depth = 2**ADDR_WIDTH.
ZERO_REG, 1, when 1 register 0 always reads 0 and ignores writes.
BYPASS, 1, when 1 a read of the address being written this cycle returns the write data.
SYNC_READ, 0, 0 = combinational read; 1 = RD1/RD2 registered (1-cycle latency).
OUT_ADDR, 2**ADDR_WIDTH-1, register index mirrored to cpu_out.

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  asynchronous, active-low reset.
RA1  input  ADDR_WIDTH  read address, port 1.
RA2  input  ADDR_WIDTH  read address, port 2.
WA  input  ADDR_WIDTH  write address.
ALUResult  input  DATA_WIDTH  write data.
write_enable  input  1  write strobe, sampled on rising clk.
clear  input  1  synchronous clear of all registers.
RD1  output  DATA_WIDTH  read data, port 1.
RD2  output  DATA_WIDTH  read data, port 2.
cpu_out  output  DATA_WIDTH  contents of register OUT_ADDR.

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers go to 0 immediately, independent of clk.
  - cpu_out = 0.
  - With SYNC_READ=1, the RD1/RD2 output registers = 0.
  - With SYNC_READ=0, RD1/RD2 = 0 because the array is 0.
  - Deassertion takes effect at the next rising edge; no write occurs on an edge while reset=0.
- Write:
  - On rising clk with reset=1, clear=0 and write_enable=1: reg[WA] <= ALUResult.
  - If ZERO_REG=1 and WA=0, the write is dropped.
- Clear:
  - On rising clk with clear=1, all registers <= 0.
  - clear has priority over a simultaneous write; the write is lost.
- Read, SYNC_READ=0:
  - RDn = reg[RAn] combinationally.
  - If BYPASS=1, write_enable=1, clear=0 and RAn==WA (and not the zero register), RDn = ALUResult.
  - Otherwise the stored value is returned; the new value is visible after the edge.
- Read, SYNC_READ=1:
  - On each rising edge RDn <= the value the SYNC_READ=0 path would present in that cycle, including the bypass rule.
  - Effective latency: 1 cycle from address to data.
  - clear=1 in a cycle forces RDn <= 0 at that edge.
- Zero register: RAn=0 with ZERO_REG=1 returns 0 in all modes, including bypass.
- cpu_out: always equals reg[OUT_ADDR] (post-edge value); never bypassed.
- Addresses: full 2**ADDR_WIDTH range is valid; no wrap or out-of-range case exists.
- Both read ports may address the same register, including WA; each obeys the rules above independently.
- Reset mid-write: reset=0 coincident with a write edge leaves the register at 0.

Test Plan:
1. Default params; reset=0 then 1; write 8'h03 to WA=10 with write_enable=1; next cycle RA1=10 -> RD1=8'h03; RA2=2 -> RD2=0; cpu_out=0.
2. write_enable=1, WA=5, ALUResult=8'h24, RA1=5 in the same cycle -> RD1=8'h24 before the edge (BYPASS=1). Repeat with BYPASS=0 -> RD1=old value (0), then 8'h24 after the edge.
3. write_enable=1, WA=0, ALUResult=8'hFF with ZERO_REG=1 -> RA1=0 reads 0 in the same cycle and all later cycles. With ZERO_REG=0 -> reads 8'hFF after the edge.
4. Write 8'hF1 to WA=15 -> cpu_out=8'hF1 after the edge. Assert clear=1 together with write_enable=1, WA=15, ALUResult=8'h77 -> cpu_out=0 and all RD=0 after the edge.
5. SYNC_READ=1, DATA_WIDTH=16, ADDR_WIDTH=5: write 16'hBEEF to reg 20, then set RA2=20 -> RD2=16'hBEEF exactly one edge after RA2 changes, not before.
6. Load regs 1..3 with nonzero values; pull reset=0 between clock edges -> RD1, RD2 and cpu_out=0 immediately, without waiting for an edge. After release, all registers read 0.
